// File: rtl/ooo_pkg.sv
// Shared types for the committed-store path: size codes, queue entry layout and sequencer FSM states.
package ooo_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } stq_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } stq_state_e;

endpackage

// File: rtl/store_commit_sequencer_stq_ring.sv
// Circular store-queue storage with head/tail pointers and occupancy count.
// Entry contents carry no reset; only the bookkeeping is cleared.
module stq_ring
    import ooo_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  stq_entry_t       push_entry_i,
    output stq_entry_t       head_entry_o,
    output logic [PTR_W-1:0] head_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output stq_entry_t       entries_o [DEPTH]
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    stq_entry_t       mem_q [DEPTH];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        head_d  = pop_i  ? head_q + 1'b1 : head_q;
        tail_d  = push_i ? tail_q + 1'b1 : tail_q;
        count_d = count_q + {{(CNT_W-1){1'b0}}, push_i} - {{(CNT_W-1){1'b0}}, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entries
            assign entries_o[gi] = mem_q[gi];
        end
    endgenerate

    assign head_entry_o = mem_q[head_q];
    assign head_ptr_o   = head_q;
    assign count_o      = count_q;

endmodule

// File: rtl/store_commit_sequencer.sv
// Drains committed stores to the data cache in order; optional store-to-load
// forwarding is built only when STQ_FWD_EN is defined.
module store_commit_sequencer
    import ooo_pkg::*;
#(
    parameter int STQ_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        st_commit_valid,
    input  logic [31:0] st_commit_addr,
    input  logic [31:0] st_commit_data,
    input  logic [1:0]  st_commit_size,
    output logic        st_commit_ready,
    output logic        MemWrite_2DM,
    output logic [31:0] data_address_2DM,
    output logic [31:0] data_write_2DM,
    output logic [1:0]  data_write_size_2DM,
    input  logic        dm_write_ack,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        stall_signal,
    input  logic [31:0] ld_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic        fwd_conflict
);

    localparam int PTR_W = $clog2(STQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    stq_state_e       state_q, state_d;
    logic             full, push, pop;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head_ptr;
    stq_entry_t       head_entry;
    stq_entry_t       push_entry;
    stq_entry_t       entries [STQ_DEPTH];
    logic [CNT_W-1:0] post_count;

    // Readiness looks at the registered count only, so an ack never frees a slot in the same cycle.
    assign full       = (count == CNT_W'(STQ_DEPTH));
    assign push       = st_commit_valid && !full;
    assign pop        = (state_q == ST_WRITE) && dm_write_ack;
    assign push_entry = '{addr: st_commit_addr, data: st_commit_data, size: st_commit_size};

    stq_ring #(.DEPTH(STQ_DEPTH)) u_ring (
        .clk          (CLK),
        .rst_n        (RESET),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i (push_entry),
        .head_entry_o (head_entry),
        .head_ptr_o   (head_ptr),
        .count_o      (count),
        .entries_o    (entries)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        post_count = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        case (state_q)
            ST_IDLE:  if (count != '0) state_d = ST_WRITE;
            ST_WRITE: if (pop && post_count == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        MemWrite_2DM        = (state_q == ST_WRITE);
        st_commit_ready     = !full;
        stall_signal        = full;
        drain_done          = drain_req && (count == '0) && (state_q == ST_IDLE);
        data_address_2DM    = '0;
        data_write_2DM      = '0;
        data_write_size_2DM = '0;
        if (count != '0) begin
            data_address_2DM    = head_entry.addr;
            data_write_2DM      = head_entry.data;
            data_write_size_2DM = head_entry.size;
        end
    end

`ifdef STQ_FWD_EN
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit      = 1'b0;
        fwd_conflict = 1'b0;
        fwd_data     = '0;
        fwd_idx      = '0;
        for (int k = 0; k < STQ_DEPTH; k++) begin
            fwd_idx = head_ptr + PTR_W'(k);
            if (CNT_W'(k) < count && entries[fwd_idx].addr[31:2] == ld_addr[31:2]) begin
                fwd_hit      = (entries[fwd_idx].size == SIZE_WORD);
                fwd_conflict = (entries[fwd_idx].size != SIZE_WORD);
                fwd_data     = (entries[fwd_idx].size == SIZE_WORD) ? entries[fwd_idx].data : '0;
            end
        end
    end
`else
    logic [STQ_DEPTH-1:0] unused_entry_bits;
    logic                 unused_fwd;
    generate
        for (genvar gi = 0; gi < STQ_DEPTH; gi++) begin : g_unused
            assign unused_entry_bits[gi] = ^entries[gi];
        end
    endgenerate
    assign unused_fwd   = ^{ld_addr, head_ptr, unused_entry_bits};
    assign fwd_hit      = 1'b0;
    assign fwd_conflict = 1'b0;
    assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_store_commit_sequencer.sv
// Directed bench for store_commit_sequencer; forwarding expectations follow STQ_FWD_EN.
module tb_store_commit_sequencer;
    import ooo_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        st_commit_valid;
    logic [31:0] st_commit_addr, st_commit_data;
    logic [1:0]  st_commit_size;
    logic        st_commit_ready, MemWrite_2DM;
    logic [31:0] data_address_2DM, data_write_2DM;
    logic [1:0]  data_write_size_2DM;
    logic        dm_write_ack, drain_req, drain_done, stall_signal;
    logic [31:0] ld_addr, fwd_data;
    logic        fwd_hit, fwd_conflict;

    int total = 0;
    int bad   = 0;

    store_commit_sequencer #(.STQ_DEPTH(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .st_commit_valid(st_commit_valid), .st_commit_addr(st_commit_addr),
        .st_commit_data(st_commit_data), .st_commit_size(st_commit_size),
        .st_commit_ready(st_commit_ready), .MemWrite_2DM(MemWrite_2DM),
        .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
        .data_write_size_2DM(data_write_size_2DM), .dm_write_ack(dm_write_ack),
        .drain_req(drain_req), .drain_done(drain_done), .stall_signal(stall_signal),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        #3;
        total++; if (MemWrite_2DM !== 1'b0) begin bad++; $display("FAIL rst_memwrite got=%b want=0", MemWrite_2DM); end
        total++; if (st_commit_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", st_commit_ready); end
        total++; if (stall_signal !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall_signal); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL rst_drain_done got=%b want=0", drain_done); end
        total++; if ({data_address_2DM, data_write_2DM, data_write_size_2DM} !== 66'h0) begin
            bad++; $display("FAIL rst_payload got=%h/%h/%h want=0", data_address_2DM, data_write_2DM, data_write_size_2DM); end
        total++; if ({fwd_hit, fwd_conflict, fwd_data} !== 34'h0) begin
            bad++; $display("FAIL rst_fwd got=%b/%b/%h want=0", fwd_hit, fwd_conflict, fwd_data); end
        $display("reset: outputs checked");
        #4 RESET = 1'b1;
        tick;
    endtask

    task automatic test_single;
        st_commit_valid = 1'b1; st_commit_addr = 32'h100; st_commit_data = 32'hDEADBEEF;
        st_commit_size = SIZE_WORD; dm_write_ack = 1'b1;
        tick;
        st_commit_valid = 1'b0;
        total++; if (MemWrite_2DM !== 1'b0) begin bad++; $display("FAIL single_t0 got=%b want=0", MemWrite_2DM); end
        tick;
        total++; if (MemWrite_2DM !== 1'b1 || data_address_2DM !== 32'h100 || data_write_2DM !== 32'hDEADBEEF || data_write_size_2DM !== SIZE_WORD) begin
            bad++; $display("FAIL single_write got=%b %h %h %h want=1 100 deadbeef 2", MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM); end
        tick;
        total++; if (MemWrite_2DM !== 1'b0 || st_commit_ready !== 1'b1 || data_address_2DM !== 32'h0) begin
            bad++; $display("FAIL single_done got=%b %b %h want=0 1 0", MemWrite_2DM, st_commit_ready, data_address_2DM); end
        dm_write_ack = 1'b0;
        $display("single: addr=100 data=deadbeef written once");
    endtask

    task automatic test_full;
        dm_write_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            st_commit_valid = 1'b1; st_commit_addr = 32'h1000 + 32'(i) * 4;
            st_commit_data = 32'hA0 + 32'(i); st_commit_size = SIZE_WORD;
            tick;
            total++; if (st_commit_ready !== (i < 7) || stall_signal !== (i == 7)) begin
                bad++; $display("FAIL full_ready_%0d got=%b/%b want=%b/%b", i, st_commit_ready, stall_signal, i < 7, i == 7); end
        end
        // A ninth store is offered while full, and again on the first ack cycle.
        st_commit_addr = 32'hBAD; st_commit_data = 32'hBAD;
        tick;
        total++; if (st_commit_ready !== 1'b0) begin bad++; $display("FAIL full_drop got=%b want=0", st_commit_ready); end
        dm_write_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (MemWrite_2DM !== 1'b1 || data_address_2DM !== 32'h1000 + 32'(i) * 4 || data_write_2DM !== 32'hA0 + 32'(i)) begin
                bad++; $display("FAIL full_order_%0d got=%b %h %h want=1 %h %h", i, MemWrite_2DM, data_address_2DM, data_write_2DM, 32'h1000 + 32'(i) * 4, 32'hA0 + 32'(i)); end
            tick;
            st_commit_valid = 1'b0;
        end
        total++; if (MemWrite_2DM !== 1'b0 || st_commit_ready !== 1'b1) begin
            bad++; $display("FAIL full_empty got=%b %b want=0 1", MemWrite_2DM, st_commit_ready); end
        dm_write_ack = 1'b0;
        $display("full: 8 stores drained in order, 9th dropped");
    endtask

    task automatic test_wrap;
        int sent = 0;
        int written = 0;
        logic accepted;
        for (int c = 0; c < 100 && written < 12; c++) begin
            st_commit_valid = (sent < 12);
            st_commit_addr  = 32'h2000 + 32'(sent) * 4;
            st_commit_data  = 32'h5000 + 32'(sent);
            st_commit_size  = SIZE_WORD;
            dm_write_ack    = (c % 2 == 1);
            #1;
            if (MemWrite_2DM && dm_write_ack) begin
                total++;
                if (data_address_2DM !== 32'h2000 + 32'(written) * 4 || data_write_2DM !== 32'h5000 + 32'(written)) begin
                    bad++; $display("FAIL wrap_%0d got=%h %h want=%h %h", written, data_address_2DM, data_write_2DM, 32'h2000 + 32'(written) * 4, 32'h5000 + 32'(written)); end
                written++;
            end
            accepted = st_commit_valid && st_commit_ready;
            tick;
            if (accepted) sent++;
        end
        st_commit_valid = 1'b0; dm_write_ack = 1'b0;
        total++; if (written != 12) begin bad++; $display("FAIL wrap_count got=%0d want=12", written); end
        tick;
        total++; if (MemWrite_2DM !== 1'b0 || st_commit_ready !== 1'b1) begin
            bad++; $display("FAIL wrap_empty got=%b %b want=0 1", MemWrite_2DM, st_commit_ready); end
        $display("wrap: %0d stores written in order", written);
    endtask

    task automatic test_ack_stall;
        st_commit_valid = 1'b1; st_commit_addr = 32'h300; st_commit_data = 32'h77; st_commit_size = SIZE_HALF;
        tick;
        st_commit_valid = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            total++; if (MemWrite_2DM !== 1'b1 || data_address_2DM !== 32'h300 || data_write_2DM !== 32'h77 || data_write_size_2DM !== SIZE_HALF) begin
                bad++; $display("FAIL stall_%0d got=%b %h %h %h want=1 300 77 1", i, MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM); end
            tick;
        end
        dm_write_ack = 1'b1;
        tick;
        dm_write_ack = 1'b0;
        total++; if (MemWrite_2DM !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", MemWrite_2DM); end
        $display("ack_stall: payload held 5 cycles");
    endtask

    task automatic test_fwd;
        logic        exp_hit, exp_conf;
        logic [31:0] exp_data;
        dm_write_ack = 1'b0;
        st_commit_valid = 1'b1; st_commit_addr = 32'h200; st_commit_data = 32'h11; st_commit_size = SIZE_WORD;
        tick;
        st_commit_data = 32'h22;
        tick;
        st_commit_valid = 1'b0;
        ld_addr = 32'h200; #1;
`ifdef STQ_FWD_EN
        exp_hit = 1'b1; exp_conf = 1'b0; exp_data = 32'h22;
`else
        exp_hit = 1'b0; exp_conf = 1'b0; exp_data = 32'h0;
`endif
        total++; if (fwd_hit !== exp_hit || fwd_conflict !== exp_conf || fwd_data !== exp_data) begin
            bad++; $display("FAIL fwd_word got=%b %b %h want=%b %b %h", fwd_hit, fwd_conflict, fwd_data, exp_hit, exp_conf, exp_data); end
        ld_addr = 32'h300; #1;
        total++; if (fwd_hit !== 1'b0 || fwd_conflict !== 1'b0 || fwd_data !== 32'h0) begin
            bad++; $display("FAIL fwd_miss got=%b %b %h want=0 0 0", fwd_hit, fwd_conflict, fwd_data); end
        st_commit_valid = 1'b1; st_commit_addr = 32'h201; st_commit_data = 32'h33; st_commit_size = SIZE_BYTE;
        tick;
        st_commit_valid = 1'b0;
        ld_addr = 32'h200; #1;
`ifdef STQ_FWD_EN
        exp_hit = 1'b0; exp_conf = 1'b1; exp_data = 32'h0;
`else
        exp_hit = 1'b0; exp_conf = 1'b0; exp_data = 32'h0;
`endif
        total++; if (fwd_hit !== exp_hit || fwd_conflict !== exp_conf || fwd_data !== exp_data) begin
            bad++; $display("FAIL fwd_conflict got=%b %b %h want=%b %b %h", fwd_hit, fwd_conflict, fwd_data, exp_hit, exp_conf, exp_data); end
        ld_addr = 32'h0;
        dm_write_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (!MemWrite_2DM) break;
        end
        dm_write_ack = 1'b0;
        total++; if (MemWrite_2DM !== 1'b0 || st_commit_ready !== 1'b1) begin
            bad++; $display("FAIL fwd_drain got=%b %b want=0 1", MemWrite_2DM, st_commit_ready); end
        $display("fwd: word hit, miss and sub-word conflict checked");
    endtask

    task automatic test_reset_drain;
        st_commit_valid = 1'b1; st_commit_addr = 32'h400; st_commit_data = 32'h44; st_commit_size = SIZE_WORD;
        tick;
        st_commit_valid = 1'b0;
        tick;
        total++; if (MemWrite_2DM !== 1'b1 || data_address_2DM !== 32'h400) begin
            bad++; $display("FAIL rd_pre got=%b %h want=1 400", MemWrite_2DM, data_address_2DM); end
        #2 RESET = 1'b0;
        #1;
        total++; if (MemWrite_2DM !== 1'b0 || st_commit_ready !== 1'b1 || data_address_2DM !== 32'h0) begin
            bad++; $display("FAIL rd_async got=%b %b %h want=0 1 0", MemWrite_2DM, st_commit_ready, data_address_2DM); end
        #1 RESET = 1'b1;
        drain_req = 1'b1; #1;
        total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL rd_drain_empty got=%b want=1", drain_done); end
        tick;
        total++; if (MemWrite_2DM !== 1'b0) begin bad++; $display("FAIL rd_abandon got=%b want=0", MemWrite_2DM); end
        st_commit_valid = 1'b1; st_commit_addr = 32'h500; st_commit_data = 32'h55;
        tick;
        st_commit_valid = 1'b0;
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL rd_drain_busy got=%b want=0", drain_done); end
        dm_write_ack = 1'b1;
        tick;
        total++; if (MemWrite_2DM !== 1'b1 || data_address_2DM !== 32'h500) begin
            bad++; $display("FAIL rd_enq_under_drain got=%b %h want=1 500", MemWrite_2DM, data_address_2DM); end
        tick;
        dm_write_ack = 1'b0;
        total++; if (drain_done !== 1'b1 || MemWrite_2DM !== 1'b0) begin
            bad++; $display("FAIL rd_drain_done got=%b %b want=1 0", drain_done, MemWrite_2DM); end
        drain_req = 1'b0;
        $display("reset_drain: async abort and drain handshake checked");
    endtask

    initial begin
        RESET = 1'b0; st_commit_valid = 1'b0; st_commit_addr = '0; st_commit_data = '0;
        st_commit_size = '0; dm_write_ack = 1'b0; drain_req = 1'b0; ld_addr = '0;
        test_reset;
        test_single;
        test_full;
        test_wrap;
        test_ack_stall;
        test_fwd;
        test_reset_drain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_commit_sequencer.md
STORE_COMMIT_SEQUENCER -- requirements
Module: store_commit_sequencer

Interface
REQ-001 SHALL have parameter STQ_DEPTH, default 8, number of committed-store entries (power of 2, minimum 2).
REQ-002 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port st_commit_valid, input, 1, ROB retiring a store this cycle.
REQ-005 SHALL have ports st_commit_addr and st_commit_data, input, 32 each, retired store address and data.
REQ-006 SHALL have port st_commit_size, input, 2, store size code, passed through unchanged.
REQ-007 SHALL have port st_commit_ready, output, 1, high when the queue is not full.
REQ-008 SHALL have port MemWrite_2DM, output, 1, write request to the data cache.
REQ-009 SHALL have ports data_address_2DM and data_write_2DM, output, 32 each, plus data_write_size_2DM, output, 2; these carry the head entry.
REQ-010 SHALL have port dm_write_ack, input, 1, cache accepted the current write.
REQ-011 SHALL have port drain_req, input, 1, plus drain_done, output, 1, for a halt/syscall drain handshake.
REQ-012 SHALL have port stall_signal, output, 1, equal to !st_commit_ready.
REQ-013 SHALL have ports ld_addr, input, 32; fwd_hit, output, 1; fwd_data, output, 32; fwd_conflict, output, 1.

Function
REQ-014 SHALL enqueue at the tail on a cycle where st_commit_valid && st_commit_ready; when full, SHALL drop valid with no state change.
REQ-015 SHALL implement a circular buffer: head/tail pointers wrap modulo STQ_DEPTH, plus a count of width clog2(STQ_DEPTH)+1.
REQ-016 SHALL have two FSM states: IDLE and WRITE.
REQ-017 IDLE->WRITE: SHALL occur at the edge where count is nonzero.
REQ-018 WRITE with dm_write_ack: SHALL pop the head; stay in WRITE if the post-pop count (including any same-cycle enqueue) is nonzero, else go to IDLE.
REQ-019 MemWrite_2DM SHALL equal (state==WRITE); address/data/size outputs SHALL be stable while MemWrite_2DM is high and ack is low.
REQ-020 Minimum latency: a store enqueued at edge t into an empty idle queue SHALL see MemWrite_2DM high in cycle t+1; back-to-back acks SHALL retire one store per cycle.
REQ-021 Simultaneous enqueue and pop SHALL leave count unchanged, with both pointers advancing.
REQ-022 Because st_commit_ready depends only on count, a full queue SHALL NOT accept an entry even on an ack cycle.
REQ-023 drain_done SHALL be high when drain_req && count==0 && state==IDLE; drain_req SHALL NOT block enqueue.
REQ-024 Branch mispredict recovery SHALL have no effect: every queued entry is architecturally committed and SHALL be written.
REQ-025 Outputs SHALL be X-free when the queue is empty: data outputs drive zero when count==0.

Reset
REQ-026 RESET low SHALL asynchronously clear pointers and count, set state IDLE, drive MemWrite_2DM=0, st_commit_ready=1, stall_signal=0, drain_done=0, and drive fwd_* and data outputs to 0.
REQ-027 Reset asserted mid-WRITE SHALL abandon the in-flight write with no pop; entry contents are not cleared.

Configuration
REQ-028 Macro STQ_FWD_EN defined: fwd_hit SHALL be set when the youngest queued entry whose address matches ld_addr[31:2] has word size; fwd_data SHALL be that entry's data. fwd_conflict SHALL be set when the youngest match is sub-word. All three SHALL be combinational, same cycle.
REQ-029 STQ_FWD_EN undefined: fwd_hit, fwd_conflict and fwd_data SHALL be tied to 0 and no compare logic SHALL be built.

Structure
REQ-030 The size-code constants (word/half/byte), the STQ entry struct (addr, data, size) and the FSM state enum SHALL live in shared package ooo_pkg.
REQ-031 Entry storage and pointer/count logic SHALL be sub-module stq_ring; the FSM and forwarding logic SHALL stay in the top module.

Verification
REQ-032 Single store: enqueue addr 0x100, data 0xDEADBEEF, size word into an empty queue, ack on the first cycle -> MemWrite_2DM high in cycle t+1 only, outputs 0x100/0xDEADBEEF, count returns to 0.
REQ-033 Full: 8 enqueues with ack held low -> st_commit_ready=0 and stall_signal=1 after the 8th; a 9th valid is dropped; then 8 acks -> FIFO order preserved.
REQ-034 Wrap: 12 stores with acks interleaved every 2nd cycle -> all 12 written in order, with pointers wrapping past index 7.
REQ-035 Ack stall: ack held low 5 cycles -> MemWrite_2DM and payload stable for all 5 cycles.
REQ-036 Forwarding (STQ_FWD_EN): queue word stores 0x200=0x11 then 0x200=0x22, ld_addr=0x200 -> fwd_hit=1, fwd_data=0x22. Then a byte store to 0x201 -> fwd_conflict=1.
REQ-037 Reset/drain: RESET low mid-WRITE -> MemWrite_2DM=0 immediately; after release with drain_req high and queue empty -> drain_done=1.
